// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo definitions: station indices, default widths, the
// invalid-tag marker and the CDB arbiter FSM state encoding.
package tomasulo_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int TAG_W_DEF  = 5;
    localparam int DATA_W_DEF = 32;

    // Reservation-station indices as seen on out_CDB_src.
    localparam logic [1:0] ST_ADD   = 2'd0;
    localparam logic [1:0] ST_MUL   = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_LOGIC = 2'd3;

    // All-ones tag: "no producer", never a real reservation station.
    localparam logic [TAG_W_DEF-1:0] INVALID_TAG = '1;

    // CDB FSM encoding.
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BCAST = 1'b1;

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Round-robin selector: first requester at or after ptr wins.
module rr_select #(
    parameter int N_REQ = tomasulo_pkg::N_REQ_DEF,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    int   cand;
    logic found;

    // Scan N_REQ candidates starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one reservation station per cycle and
// broadcasts its registered result one cycle later.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        in_req,
    input  logic [N_REQ*TAG_W-1:0]  in_tag,
    input  logic [N_REQ*DATA_W-1:0] in_val,
    input  logic [N_REQ*4-1:0]      in_icc,
    input  logic                    in_hold,
    output logic [N_REQ-1:0]        out_grant,
    output logic                    out_CDB_broadcast,
    output logic [TAG_W-1:0]        out_CDB_tag,
    output logic [DATA_W-1:0]       out_CDB_val,
    output logic [3:0]              out_ICC_flags,
    output logic [1:0]              out_CDB_src,
    output logic                    out_err_tag
);

    localparam int                IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TAG_W-1:0]  INV_TAG = '1;

    logic [IDX_W-1:0]  ptr;
    logic              armed;
    logic [0:0]        state;
    logic [N_REQ-1:0]  sel_grant;
    logic [IDX_W-1:0]  sel_idx;
    logic              granted;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_val;
    logic [3:0]        win_icc;
    logic              win_valid;
    logic [TAG_W-1:0]  tag_r;
    logic [DATA_W-1:0] val_r;
    logic [3:0]        icc_r;
    logic [1:0]        src_r;
    logic              err_r;

    rr_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (in_req),
        .ptr   (ptr),
        .grant (sel_grant),
        .idx   (sel_idx)
    );

    // Grant is blocked by hold and during the first cycle after reset release.
    always_comb begin
        out_grant = (armed && !in_hold) ? sel_grant : '0;
        granted   = |out_grant;
        win_tag   = in_tag[int'(sel_idx)*TAG_W +: TAG_W];
        win_val   = in_val[int'(sel_idx)*DATA_W +: DATA_W];
        win_icc   = in_icc[int'(sel_idx)*4 +: 4];
        win_valid = (win_tag != INV_TAG);
    end

    // Arm grants one edge after reset, advance ptr past each winner, track FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            ptr   <= '0;
            state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            armed <= 1'b1;
            state <= granted ? S_BCAST : S_IDLE;
            if (granted)
                ptr <= (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
        end
    end

    // Capture the winner; an invalid-tag winner is consumed but leaves the
    // value/flags/source registers untouched and raises the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: output registers are reset because their idle values are visible on the bus.
            tag_r <= INV_TAG;
            val_r <= '0;
            icc_r <= '0;
            src_r <= '0;
            err_r <= 1'b0;
        end else begin
            tag_r <= granted ? win_tag : INV_TAG;
            if (granted && win_valid) begin
                val_r <= win_val;
                icc_r <= win_icc;
                src_r <= 2'(sel_idx);
            end
            if (granted && !win_valid)
                err_r <= 1'b1;
        end
    end

    // Bus is valid only in BCAST with a real tag; idle tag reads all ones.
    always_comb begin
        out_CDB_broadcast = (state == S_BCAST) && (tag_r != INV_TAG);
        out_CDB_tag       = tag_r;
        out_CDB_val       = val_r;
        out_ICC_flags     = icc_r;
        out_CDB_src       = src_r;
        out_err_tag       = err_r;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter.
module tb_cdb_arbiter;
    import tomasulo_pkg::*;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_req;
    logic [N*TW-1:0] in_tag;
    logic [N*DW-1:0] in_val;
    logic [N*4-1:0]  in_icc;
    logic            in_hold;
    logic [N-1:0]    out_grant;
    logic            out_CDB_broadcast;
    logic [TW-1:0]   out_CDB_tag;
    logic [DW-1:0]   out_CDB_val;
    logic [3:0]      out_ICC_flags;
    logic [1:0]      out_CDB_src;
    logic            out_err_tag;

    logic [TW-1:0] tag_s [N];
    logic [DW-1:0] val_s [N];
    logic [3:0]    icc_s [N];

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] val;
        logic [3:0]    icc;
        logic [1:0]    src;
    } bc_t;

    bc_t          bc_q [$];
    logic [N-1:0] gr_q [$];

    int n_pass  = 0;
    int n_total = 0;

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_req            (in_req),
        .in_tag            (in_tag),
        .in_val            (in_val),
        .in_icc            (in_icc),
        .in_hold           (in_hold),
        .out_grant         (out_grant),
        .out_CDB_broadcast (out_CDB_broadcast),
        .out_CDB_tag       (out_CDB_tag),
        .out_CDB_val       (out_CDB_val),
        .out_ICC_flags     (out_ICC_flags),
        .out_CDB_src       (out_CDB_src),
        .out_err_tag       (out_err_tag)
    );

    always #5 clk = ~clk;

    always_comb begin
        in_tag = '0;
        in_val = '0;
        in_icc = '0;
        for (int i = 0; i < N; i++) begin
            in_tag[i*TW +: TW] = tag_s[i];
            in_val[i*DW +: DW] = val_s[i];
            in_icc[i*4 +: 4]   = icc_s[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Queue the grant for station k and, if it carries a real tag, its broadcast.
    task automatic expect_grant(input int k, input bit bcast);
        bc_t e;
        gr_q.push_back(N'(1 << k));
        if (bcast) begin
            e.tag = tag_s[k];
            e.val = val_s[k];
            e.icc = icc_s[k];
            e.src = 2'(k);
            bc_q.push_back(e);
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic h);
        in_req  = r;
        in_hold = h;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 64'(out_grant), 64'd0);
        check({tag, "_bcast"}, 64'(out_CDB_broadcast), 64'd0);
        check({tag, "_tag"},   64'(out_CDB_tag), 64'(INVALID_TAG));
        check({tag, "_val"},   64'(out_CDB_val), 64'd0);
        check({tag, "_icc"},   64'(out_ICC_flags), 64'd0);
        check({tag, "_src"},   64'(out_CDB_src), 64'd0);
        check({tag, "_err"},   64'(out_err_tag), 64'd0);
    endtask

    // Monitor: every observed grant or broadcast must match the queue head.
    initial begin : monitor
        bc_t          e;
        logic [N-1:0] g;
        forever begin
            @(negedge clk);
            if (out_grant != '0) begin
                if (gr_q.size() == 0) check("unexpected_grant", 64'(out_grant), 64'd0);
                else begin
                    g = gr_q.pop_front();
                    check("grant", 64'(out_grant), 64'(g));
                end
            end
            if (out_CDB_broadcast) begin
                if (bc_q.size() == 0) check("unexpected_bcast", 64'd1, 64'd0);
                else begin
                    e = bc_q.pop_front();
                    check("bcast", 64'({out_CDB_tag, out_CDB_val, out_ICC_flags, out_CDB_src}), 64'(e));
                end
            end
        end
    end

    initial begin : stimulus
        tag_s[0] = 5'd2;  val_s[0] = 32'h0000_0010; icc_s[0] = 4'b0100;
        tag_s[1] = 5'd7;  val_s[1] = 32'h0000_0111; icc_s[1] = 4'b0001;
        tag_s[2] = 5'd9;  val_s[2] = 32'h0000_0222; icc_s[2] = 4'b0010;
        tag_s[3] = 5'd12; val_s[3] = 32'h0000_0333; icc_s[3] = 4'b1000;
        rst_n   = 1'b0;
        in_req  = '0;
        in_hold = 1'b0;
        next_cycle();
        next_cycle();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        next_cycle();

        // Single request from station 0.
        expect_grant(ST_ADD, 1'b1);
        drive(4'b0001, 1'b0);
        next_cycle();
        drive(4'b0000, 1'b0);
        check("s1_bcast_n1", 64'(out_CDB_broadcast), 64'd1);
        next_cycle();
        drive(4'b0000, 1'b0);
        check("s1_bcast_n2", 64'(out_CDB_broadcast), 64'd0);
        check("s1_tag_n2", 64'(out_CDB_tag), 64'h1F);
        check("s1_val_hold", 64'(out_CDB_val), 64'h10);
        next_cycle();

        // Bring ptr back to 0, then all four request for 8 cycles.
        expect_grant(ST_LOGIC, 1'b1);
        drive(4'b1000, 1'b0);
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            expect_grant(i % N, 1'b1);
            drive(4'b1111, 1'b0);
            check("s2_bcast_run", 64'(out_CDB_broadcast), 64'd1);
            next_cycle();
        end
        drive(4'b0000, 1'b0);
        check("s2_bcast_last", 64'(out_CDB_broadcast), 64'd1);
        next_cycle();

        // ptr=2 via a grant to 1, then stations 1 and 3 compete.
        expect_grant(ST_MUL, 1'b1);
        drive(4'b0010, 1'b0);
        next_cycle();
        expect_grant(ST_LOGIC, 1'b1);
        drive(4'b1010, 1'b0);
        next_cycle();
        expect_grant(ST_MUL, 1'b1);
        drive(4'b0010, 1'b0);
        next_cycle();
        drive(4'b0000, 1'b0);
        next_cycle();
        drive(4'b0000, 1'b0);
        next_cycle();

        // Hold blocks station 2; on release ptr=2 picks 2 over 1.
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b1);
            check("s4_hold_grant", 64'(out_grant), 64'd0);
            check("s4_hold_bcast", 64'(out_CDB_broadcast), 64'd0);
            next_cycle();
        end
        expect_grant(ST_LOAD, 1'b1);
        drive(4'b0110, 1'b0);
        next_cycle();
        expect_grant(ST_MUL, 1'b1);
        drive(4'b0010, 1'b0);
        next_cycle();
        drive(4'b0000, 1'b0);
        next_cycle();

        // Invalid tag: granted, not broadcast, sticky error.
        tag_s[1] = 5'h1F; val_s[1] = 32'hDEAD_BEEF; icc_s[1] = 4'hF;
        expect_grant(ST_MUL, 1'b0);
        drive(4'b0010, 1'b0);
        next_cycle();
        drive(4'b0000, 1'b0);
        check("s5_bcast", 64'(out_CDB_broadcast), 64'd0);
        check("s5_tag", 64'(out_CDB_tag), 64'h1F);
        check("s5_err", 64'(out_err_tag), 64'd1);
        check("s5_val_hold", 64'(out_CDB_val), 64'h111);
        check("s5_icc_hold", 64'(out_ICC_flags), 64'h1);
        next_cycle();
        drive(4'b0000, 1'b0);
        check("s5_err_sticky", 64'(out_err_tag), 64'd1);
        next_cycle();
        tag_s[1] = 5'd7; val_s[1] = 32'h0000_0111; icc_s[1] = 4'b0001;

        // Reset pulse while a broadcast is on the bus.
        expect_grant(ST_ADD, 1'b1);
        drive(4'b0001, 1'b0);
        next_cycle();
        drive(4'b0000, 1'b0);
        check("s6_bcast_pre", 64'(out_CDB_broadcast), 64'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("s6_async");
        in_req = 4'b0001;
        #1 check("s6_grant_in_rst", 64'(out_grant), 64'd0);
        rst_n = 1'b1;
        #1 check("s6_grant_after_rel", 64'(out_grant), 64'd0);
        next_cycle();
        check("s6_no_first_edge_grant", 64'(out_CDB_broadcast), 64'd0);
        expect_grant(ST_ADD, 1'b1);
        drive(4'b0001, 1'b0);
        next_cycle();
        drive(4'b0000, 1'b0);
        check("s6_bcast_after", 64'(out_CDB_broadcast), 64'd1);
        next_cycle();
        drive(4'b0000, 1'b0);
        next_cycle();

        check("grant_queue_drained", 64'(gr_q.size()), 64'd0);
        check("bcast_queue_drained", 64'(bc_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter N_REQ, default 4, SHALL set the number of requesting reservation stations (0=ADD, 1=MUL, 2=LOAD, 3=LOGIC).
REQ-003 Parameter TAG_W, default 5, SHALL set the reservation-station tag width.
REQ-004 Parameter DATA_W, default 32, SHALL set the result width.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- in_req  in  N_REQ  per-station result-ready request.
- in_tag  in  N_REQ*TAG_W  per-station result tag, packed with station 0 at the LSBs.
- in_val  in  N_REQ*DATA_W  per-station result value, same packing.
- in_icc  in  N_REQ*4  per-station ICC flags {c,v,z,n}.
- in_hold  in  1  CDB consumer stall.
- out_grant  out  N_REQ  one-hot grant pulse.
- out_CDB_broadcast  out  1  bus-valid pulse.
- out_CDB_tag  out  TAG_W  broadcast tag.
- out_CDB_val  out  DATA_W  broadcast value.
- out_ICC_flags  out  4  broadcast flags.
- out_CDB_src  out  2  index of the granted station.
- out_err_tag  out  1  sticky flag: an INVALID_TAG request was seen.

Function
REQ-006 A requester SHALL hold in_req high, with its tag, val and icc stable, from assertion until the cycle in which its out_grant bit is high; it SHALL deassert in the following cycle.
REQ-007 The arbiter SHALL grant at most one requester per cycle, selected by round-robin starting at the priority pointer ptr.
REQ-008 After a grant to index k, ptr SHALL become (k+1) mod N_REQ; with no grant, ptr SHALL be unchanged.
REQ-009 out_grant SHALL be combinational from the current in_req, ptr and in_hold, and SHALL be all-zero when in_hold=1.
REQ-010 The FSM SHALL have two states: IDLE (no broadcast in flight) and BCAST (an output-register broadcast is valid this cycle).
REQ-011 FSM transitions SHALL be:
- IDLE->BCAST on a grant.
- BCAST->BCAST on a grant in the same cycle.
- BCAST->IDLE with no grant.
REQ-012 The winner's tag, val, icc and index SHALL be registered on the grant edge, so out_CDB_broadcast is high exactly 1 cycle after out_grant, for 1 cycle per grant.
REQ-013 Back-to-back grants SHALL give a 1-result-per-cycle throughput; out_CDB_broadcast SHALL remain high across consecutive grants.
REQ-014 When out_CDB_broadcast=0, out_CDB_tag SHALL equal INVALID_TAG (all ones) and out_CDB_val, out_ICC_flags and out_CDB_src SHALL hold their last values.
REQ-015 A request whose tag equals INVALID_TAG SHALL still be granted, and therefore consumed, but SHALL NOT be broadcast; it SHALL set out_err_tag.
REQ-016 A requester that asserts in_req in the cycle after its own grant SHALL be treated as a new request.
REQ-017 in_hold SHALL NOT cancel a broadcast already registered; it SHALL only block new grants.
REQ-018 With all N_REQ requesting continuously, each station SHALL be granted exactly once in every N_REQ consecutive grants.

Reset
REQ-019 While rst_n=0, the block SHALL force:
- ptr=0, state=IDLE.
- out_grant=0, out_CDB_broadcast=0.
- out_CDB_tag=INVALID_TAG, out_CDB_val=0, out_ICC_flags=0, out_CDB_src=0.
- out_err_tag=0.
REQ-020 A reset asserted mid-broadcast SHALL drop that broadcast immediately, and the result SHALL be lost; requesters SHALL re-request after reset.
REQ-021 No grant SHALL occur in the first clock edge after rst_n deasserts.

Structure
REQ-022 INVALID_TAG, the station index constants and TAG_W/DATA_W defaults SHALL reside in the shared tomasulo package.
REQ-023 The round-robin selector SHALL be one sub-module, rr_select (inputs req and ptr; outputs one-hot grant and index); the FSM and output registers SHALL stay in cdb_arbiter.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then only station 0 requests tag=2, val=0x0000_0010, icc=4'b0100 -> out_grant=0001 in cycle N; in cycle N+1, broadcast=1, tag=2, val=0x10, src=0; in cycle N+2, broadcast=0 and tag=5'h1F.
- All 4 stations request continuously for 8 cycles from ptr=0 -> grant order 0,1,2,3,0,1,2,3 and broadcast high for 8 consecutive cycles.
- Stations 1 and 3 request while ptr=2 -> station 3 granted first, then station 1; ptr ends at 2.
- in_hold=1 for 3 cycles with station 2 requesting -> no grants and no broadcast; station 2 is granted in the first cycle after hold drops.
- Station 1 requests with tag=5'h1F -> granted, no broadcast, out_err_tag=1 until reset.
- rst_n pulsed low in the cycle broadcast=1 -> all outputs reach reset values asynchronously, and no grant occurs in the first edge after release.
